window_buffer: RTL

//  Window generator feeding the filter operation stage. Takes a raster-order stream of
//  9-bit pixel words {valid, pixel[7:0]}, buffers Ope_Size-1 image lines, and presents a

---
 rtl/window_buffer_pkg.sv | 9 +
 rtl/window_buffer_line_fifo.sv | 24 ++
 rtl/window_buffer.sv | 86 ++++++++
 3 files changed

// File: rtl/window_buffer_pkg.sv
// Shared definitions for the window generator: pixel word layout and element type.
package window_buffer_pkg;
   localparam int PIX_W        = 8;
   localparam int ELEM_W       = 9;
   localparam int VALID_BIT    = 8;
   localparam int DEF_OPE_SIZE = 3;

   typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/window_buffer_line_fifo.sv
// One image line of delay: Depth-deep pixel memory addressed by column, read-before-write.
module line_fifo
   import window_buffer_pkg::*;
#(
   parameter int Depth = 640,
   parameter int AW    = $clog2(Depth)
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic [AW-1:0] i_addr,
   input  pix_t          i_din,
   output pix_t          o_dout
);

   pix_t r_mem [Depth];

   always_ff @(posedge clk) begin
      if (i_en) r_mem[i_addr] <= i_din;
   end

   // Asynchronous read returns the value from one line ago before this edge overwrites it.
   assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/window_buffer.sv
// Raster-stream to Ope_Size x Ope_Size neighbourhood generator with chained line buffers.
module window_buffer
   import window_buffer_pkg::*;
#(
   parameter int Ope_Size   = DEF_OPE_SIZE,
   parameter int Img_Width  = 640,
   parameter int Img_Height = 480
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  reflesh,
   input  logic [ELEM_W-1:0]                     in,
   output logic [ELEM_W*Ope_Size*Ope_Size-1:0]   data_bus
);

   localparam int CW = $clog2(Img_Width);
   localparam int RW = $clog2(Img_Height);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   pix_t          r_win [Ope_Size][Ope_Size];
   logic          r_valid;

   logic          w_accept;
   logic          w_wv;
   pix_t          w_tap [Ope_Size];

   assign w_accept = in[VALID_BIT];
   assign w_wv     = w_accept && (r_row >= RW'(Ope_Size-1)) && (r_col >= CW'(Ope_Size-1));

   // Tap k feeds window row k; line buffer k is fed from tap k+1, so row 0 is the oldest line.
   assign w_tap[Ope_Size-1] = in[PIX_W-1:0];

   for (genvar k = 0; k < Ope_Size-1; k++) begin : g_line
      line_fifo #(
         .Depth (Img_Width)
      ) u_line_fifo (
         .clk    (clk),
         .i_en   (w_accept && !reflesh),
         .i_addr (r_col),
         .i_din  (w_tap[k+1]),
         .o_dout (w_tap[k])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col   <= '0;
         r_row   <= '0;
         r_valid <= 1'b0;
         for (int unsigned y = 0; y < Ope_Size; y++)
            for (int unsigned x = 0; x < Ope_Size; x++)
               r_win[y][x] <= '0;
      end else if (reflesh) begin
         r_col   <= '0;
         r_row   <= '0;
         r_valid <= 1'b0;
         for (int unsigned y = 0; y < Ope_Size; y++)
            for (int unsigned x = 0; x < Ope_Size; x++)
               r_win[y][x] <= '0;
      end else if (w_accept) begin
         r_valid <= w_wv;
         for (int unsigned y = 0; y < Ope_Size; y++) begin
            for (int unsigned x = 0; x < Ope_Size-1; x++)
               r_win[y][x] <= r_win[y][x+1];
            r_win[y][Ope_Size-1] <= w_tap[y];
         end
         if (r_col == CW'(Img_Width-1)) begin
            r_col <= '0;
            r_row <= (r_row == RW'(Img_Height-1)) ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end else begin
         r_valid <= 1'b0;
      end
   end

   always_comb begin
      data_bus = '0;
      for (int unsigned y = 0; y < Ope_Size; y++)
         for (int unsigned x = 0; x < Ope_Size; x++)
            data_bus[((y*Ope_Size)+x)*ELEM_W +: ELEM_W] = {r_valid, r_win[y][x]};
   end

endmodule
